seq_mult_ctrl: RTL and testbench

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

---
 rtl/seq_mult_pkg.sv | 14 +
 rtl/seq_mult_add.sv | 13 +
 rtl/seq_mult_ctrl.sv | 102 ++++++++++
 tb/tb_seq_mult_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// The optional early-exit build is selected with SEQ_MULT_EARLY_EXIT_EN.
package seq_mult_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned ITER_W    = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mult_add.sv
// Combinational accumulate adder; kept separate so a faster adder can drop in.
module seq_mult_add #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);

    // Carry-out is dropped: the accumulated product never exceeds W bits.
    assign s = a + b;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add unsigned multiplier with valid/ready handshakes on both sides.
// Define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               ovf
);

    localparam int unsigned IterW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e               state_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [IterW-1:0]     iter_q;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic [2*WIDTH-1:0]   sum;
    logic                 last_iter;

    seq_mult_add #(
        .W (2 * WIDTH)
    ) u_add (
        .a (acc_q),
        .b (mcand_q),
        .s (sum)
    );

`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Stop once the shifted-out multiplier would leave nothing further to add.
    assign last_iter = (iter_q == IterW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last_iter = (iter_q == IterW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            iter_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        acc_q      <= '0;
                        mcand_q    <= {{WIDTH{1'b0}}, a};
                        mplier_q   <= b;
                        iter_q     <= '0;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (mplier_q[0]) begin
                        acc_q <= sum;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    iter_q   <= iter_q + IterW'(1);
                    if (last_iter) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = acc_q;
    assign ovf       = |acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl against an arithmetic reference model.
// Latency expectations follow SEQ_MULT_EARLY_EXIT_EN when it is defined.
module tb_seq_mult_ctrl;

    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           ovf;

    int vectors    = 0;
    int miscompares = 0;
    int cycle      = 0;

    seq_mult_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic wait_edge();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xe;
        logic [2*W-1:0] ye;
        xe = {{W{1'b0}}, x};
        ye = {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] y);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int hi;
        hi = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (y[i]) hi = i + 1;
        end
        return (hi < 1) ? 1 : hi;
`else
        return int'(W);
`endif
    endfunction

    // One complete operation with optional back-pressure on the output side.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input int hold);
        logic [2*W-1:0] exp_p;
        logic           exp_o;
        int             n;
        exp_p = ref_prod(oa, ob);
        exp_o = (exp_p >> W) != 0;
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready: got %b want 1", in_ready);
        end
        a = oa;
        b = ob;
        in_valid = 1'b1;
        wait_edge();
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            wait_edge();
            n++;
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
        end
        vectors++;
        if (n != ref_lat(ob)) begin
            miscompares++;
            $display("FAIL latency a=%h b=%h: got %0d want %0d", oa, ob, n, ref_lat(ob));
        end
        if (n >= 200) return;
        vectors++;
        if (product !== exp_p || ovf !== exp_o || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL result a=%h b=%h: got %h ovf=%b rdy=%b want %h ovf=%b rdy=0",
                     oa, ob, product, ovf, in_ready, exp_p, exp_o);
        end
        for (int i = 0; i < hold; i++) begin
            wait_edge();
            vectors++;
            if (out_valid !== 1'b1 || product !== exp_p || ovf !== exp_o || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold%0d: got v=%b p=%h o=%b r=%b want v=1 p=%h o=%b r=0",
                         i, out_valid, product, ovf, in_ready, exp_p, exp_o);
            end
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        wait_edge();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL handshake: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        #12;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got r=%b v=%b p=%h o=%b want r=1 v=0 p=0 o=0",
                     in_ready, out_valid, product, ovf);
        end
        rst_n = 1'b1;
        wait_edge();
    endtask

    task automatic test_basic();
        do_op(16'd3, 16'd5, 0);
        do_op(16'hFFFF, 16'hFFFF, 0);
    endtask

    task automatic test_hold();
        do_op(16'h1234, 16'h0002, 5);
    endtask

    task automatic test_boundary();
        do_op(16'h0000, 16'hFFFF, 0);
        do_op(16'hFFFF, 16'h0000, 1);
        do_op(16'h0001, 16'h8000, 0);
        do_op(16'h0000, 16'h0000, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom) >> $urandom_range(0, W - 1);
            do_op(ra, rb, $urandom_range(0, 3));
        end
    endtask

    // in_valid held high: each accept follows its handshake after exactly one idle cycle.
    task automatic test_back_to_back();
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        int           qc[$];
        int           accepted;
        int           got;
        int           last_done;
        logic [2*W-1:0] exp_p;
        accepted  = 0;
        got       = 0;
        last_done = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        for (int c = 0; c < 400 && got < 4; c++) begin
            if (out_valid === 1'b1) begin
                exp_p = ref_prod(qa[0], qb[0]);
                vectors++;
                if (qa.size() == 0 || product !== exp_p
                    || cycle - qc[0] != ref_lat(qb[0]) + 1) begin
                    miscompares++;
                    $display("FAIL b2b_result%0d: got %h after %0d want %h after %0d",
                             got, product, cycle - qc[0], exp_p, ref_lat(qb[0]) + 1);
                end
                void'(qa.pop_front());
                void'(qb.pop_front());
                void'(qc.pop_front());
                last_done = cycle;
                got++;
            end
            if (in_ready === 1'b1) begin
                if (last_done >= 0) begin
                    vectors++;
                    if (cycle != last_done + 1) begin
                        miscompares++;
                        $display("FAIL b2b_gap: got accept at %0d want %0d", cycle, last_done + 1);
                    end
                end
                if (accepted < 4) begin
                    qa.push_back(a);
                    qb.push_back(b);
                    qc.push_back(cycle);
                    accepted++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                a = W'($urandom);
                b = W'($urandom) >> $urandom_range(0, W - 1);
            end
            if (got < 4) wait_edge();
        end
        vectors++;
        if (got != 4 || accepted != 4) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results %0d accepts want 4 4", got, accepted);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_edge();
        wait_edge();
    endtask

    task automatic test_reset_abort();
        a = 16'h00FF;
        b = 16'h00FF;
        in_valid = 1'b1;
        wait_edge();
        in_valid = 1'b0;
        repeat (7) wait_edge();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: got r=%b v=%b p=%h o=%b want r=1 v=0 p=0 o=0",
                     in_ready, out_valid, product, ovf);
        end
        #2;
        rst_n = 1'b1;
        wait_edge();
        for (int i = 0; i < int'(W) + 2; i++) begin
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet%0d: got v=%b want 0", i, out_valid);
            end
            wait_edge();
        end
        do_op(16'd2, 16'd2, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_boundary();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
